// File: rtl/voice_mix_sequencer_pkg.sv
// Shared definitions for the voice mixing path: FSM encodings and default widths
// reused by the envelope and mixer stages.
package voice_mix_sequencer_pkg;

    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_C_WIDTH      = 32;
    localparam int DEF_NUM_VOICES   = 8;
    // Gains are unsigned Q0.16, so the scaled sample sits this far up the product.
    localparam int GAIN_FRAC_BITS   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUTPUT = 3'd4
    } mix_state_t;

endpackage

// File: rtl/voice_mix_sequencer_saturate.sv
// Combinational signed clamp from the accumulator width down to sample width,
// flagging when the value had to be clipped.
module mix_saturate
    import voice_mix_sequencer_pkg::*;
#(
    parameter int IN_W  = DEF_SAMPLE_WIDTH + 4,
    parameter int OUT_W = DEF_SAMPLE_WIDTH
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             clip
);

    logic [IN_W-OUT_W:0] upper;

    // The value fits when every bit from the output sign bit upward agrees.
    assign upper = din[IN_W-1:OUT_W-1];

    always_comb begin
        clip = !((&upper) || !(|upper));
        if (!clip) begin
            dout = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/voice_mix_sequencer.sv
// Scales each enabled voice by its gain through the shared multiplier, one voice
// at a time, and emits one saturated signed mix sample per request.
module voice_mix_sequencer
    import voice_mix_sequencer_pkg::*;
#(
    parameter int C_WIDTH      = DEF_C_WIDTH,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int NUM_VOICES   = DEF_NUM_VOICES
) (
    input  logic                               ctl_clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] samples_in,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] gains_in,
    input  logic [NUM_VOICES-1:0]              voice_en,
    output logic [C_WIDTH-1:0]                 mul_a,
    output logic [C_WIDTH-1:0]                 mul_b,
    output logic                               mul_trigger,
    input  logic                               mul_ready,
    input  logic                               mul_done,
    input  logic [C_WIDTH-1:0]                 mul_y,
    output logic [SAMPLE_WIDTH-1:0]            mix_out,
    output logic                               mix_valid,
    output logic                               clip,
    output logic                               busy
);

    localparam int SW    = SAMPLE_WIDTH;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = SW + $clog2(NUM_VOICES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [SW:0]      MAG_ONE  = 1;

    mix_state_t                state;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_upd;
    logic signed [ACC_W-1:0]   term;
    logic [NUM_VOICES*SW-1:0]  samples_q;
    logic [NUM_VOICES*SW-1:0]  gains_q;
    logic [NUM_VOICES-1:0]     en_q;
    logic [SW-1:0]             cur_sample;
    logic [SW-1:0]             cur_gain;
    logic [SW:0]               cur_mag;
    logic [SW-1:0]             prod_p;
    logic                      take_done;
    logic                      last_voice;
    logic [SW-1:0]             sat_out;
    logic                      sat_clip;
    logic                      unused_y;

    assign cur_sample = samples_q[idx*SW +: SW];
    assign cur_gain   = gains_q[idx*SW +: SW];
    // One extra bit so |-2^(SW-1)| is representable as an unsigned magnitude.
    assign cur_mag    = cur_sample[SW-1] ? (~{1'b1, cur_sample} + MAG_ONE)
                                         : {1'b0, cur_sample};
    assign prod_p     = mul_y[GAIN_FRAC_BITS +: SW];
    assign unused_y   = ^mul_y;
    assign last_voice = (idx == LAST_IDX);

    // Multiplier handshake: a trigger pulse is only raised from ISSUE while mul_ready
    // is high; operands stay stable until the result is taken; mul_done counts only
    // in a cycle after the trigger pulse, and only while WAIT is pending.
    assign take_done  = (state == ST_WAIT) && mul_done && !mul_trigger;

    always_comb begin
        term    = $signed({{(ACC_W-SW){1'b0}}, prod_p});
        acc_upd = acc;
        if (take_done) begin
            acc_upd = cur_sample[SW-1] ? (acc - term) : (acc + term);
        end
    end

    mix_saturate #(
        .IN_W  (ACC_W),
        .OUT_W (SW)
    ) u_sat (
        .din  (acc_upd),
        .dout (sat_out),
        .clip (sat_clip)
    );

    always_ff @(posedge ctl_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            acc         <= '0;
            samples_q   <= '0;
            gains_q     <= '0;
            en_q        <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_trigger <= 1'b0;
            mix_out     <= '0;
            mix_valid   <= 1'b0;
            clip        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            mul_trigger <= 1'b0;
            mix_valid   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        samples_q <= samples_in;
                        gains_q   <= gains_in;
                        en_q      <= voice_en;
                        acc       <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (en_q[idx]) begin
                        mul_a <= {{(C_WIDTH-SW-1){1'b0}}, cur_mag};
                        mul_b <= {{(C_WIDTH-SW){1'b0}}, cur_gain};
                        state <= ST_ISSUE;
                    end else if (last_voice) begin
                        mix_out   <= sat_out;
                        clip      <= sat_clip;
                        mix_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (mul_ready) begin
                        mul_trigger <= 1'b1;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (take_done) begin
                        acc <= acc_upd;
                        if (last_voice) begin
                            mix_out   <= sat_out;
                            clip      <= sat_clip;
                            mix_valid <= 1'b1;
                            state     <= ST_OUTPUT;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_OUTPUT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Bench for voice_mix_sequencer: behavioural multiplier, directed and random mixes
// checked against an arithmetic reference of the mixing rules.
module tb_voice_mix_sequencer;

    logic         ctl_clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] samples_in;
    logic [127:0] gains_in;
    logic [7:0]   voice_en;
    logic [31:0]  mul_a;
    logic [31:0]  mul_b;
    logic         mul_trigger;
    logic         mul_ready;
    logic         mul_done;
    logic [31:0]  mul_y;
    logic [15:0]  mix_out;
    logic         mix_valid;
    logic         clip;
    logic         busy;

    int n_cmp = 0;
    int n_mis = 0;

    // multiplier model state
    int          lat = 1;
    int          cnt;
    logic [31:0] prod_r;
    logic [31:0] model_y;
    logic        model_done;
    bit          spur_en = 1'b0;
    bit          stray_done = 1'b0;
    int          trig_cnt = 0;
    logic [31:0] last_a;
    logic [31:0] last_b;

    always #5 ctl_clk = ~ctl_clk;

    voice_mix_sequencer dut (
        .ctl_clk     (ctl_clk),
        .reset       (reset),
        .start       (start),
        .samples_in  (samples_in),
        .gains_in    (gains_in),
        .voice_en    (voice_en),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_trigger (mul_trigger),
        .mul_ready   (mul_ready),
        .mul_done    (mul_done),
        .mul_y       (mul_y),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .clip        (clip),
        .busy        (busy)
    );

    assign mul_done = model_done | (spur_en & mul_trigger) | stray_done;
    assign mul_y    = (stray_done | (spur_en & mul_trigger)) ? 32'hDEAD_BEEF : model_y;

    always @(posedge ctl_clk or posedge reset) begin
        if (reset) begin
            cnt        <= 0;
            model_done <= 1'b0;
            model_y    <= '0;
            prod_r     <= '0;
        end else begin
            model_done <= 1'b0;
            if (mul_trigger) begin
                prod_r <= mul_a * mul_b;
                cnt    <= lat;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    model_done <= 1'b1;
                    model_y    <= prod_r;
                end
            end
        end
    end

    always @(posedge ctl_clk) begin
        if (mul_trigger === 1'b1) begin
            trig_cnt <= trig_cnt + 1;
            last_a   <= mul_a;
            last_b   <= mul_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each enabled voice contributes sign(s) * floor(|s| * g / 2^16),
    // the sum is clamped to the signed 16-bit range.
    function automatic void ref_mix(input logic [7:0] en, input logic [127:0] s,
                                    input logic [127:0] g, output logic [15:0] mo,
                                    output logic c);
        longint acc = 0;
        for (int v = 0; v < 8; v++) begin
            if (en[v]) begin
                longint sv  = longint'($signed(s[v*16 +: 16]));
                longint gv  = longint'(g[v*16 +: 16]);
                longint mag = (sv < 0) ? -sv : sv;
                longint p   = (mag * gv) / 65536;
                acc += (sv < 0) ? -p : p;
            end
        end
        c = 1'b1;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        else c = 1'b0;
        mo = 16'(acc);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_mix(input string tag, input logic [7:0] en, input logic [127:0] s,
                          input logic [127:0] g, input int hold, input bit poke,
                          input int want_lat);
        logic [15:0] exp_mo;
        logic        exp_c;
        int          t0;
        int          cyc;
        bit          seen;
        ref_mix(en, s, g, exp_mo, exp_c);
        @(negedge ctl_clk);
        samples_in = s;
        gains_in   = g;
        voice_en   = en;
        start      = 1'b1;
        if (hold > 0) mul_ready = 1'b0;
        t0 = trig_cnt;
        @(negedge ctl_clk);
        start      = 1'b0;
        samples_in = rnd128();
        gains_in   = rnd128();
        voice_en   = 8'($urandom);
        check({tag, "_busy"}, busy, 1);
        seen = 1'b0;
        for (cyc = 1; cyc <= 400; cyc++) begin
            if (mix_valid) begin
                seen = 1'b1;
                break;
            end
            if (cyc == hold) begin
                check({tag, "_ready_hold"}, trig_cnt - t0, 0);
                mul_ready = 1'b1;
            end
            if (poke) start = (cyc == 3);
            @(negedge ctl_clk);
        end
        start     = 1'b0;
        mul_ready = 1'b1;
        check({tag, "_valid_seen"}, seen, 1);
        if (want_lat > 0) check({tag, "_latency"}, cyc, want_lat);
        check({tag, "_mix_out"}, mix_out, exp_mo);
        check({tag, "_clip"}, clip, exp_c);
        check({tag, "_triggers"}, trig_cnt - t0, $countones(en));
        @(negedge ctl_clk);
        check({tag, "_valid_pulse"}, mix_valid, 0);
        check({tag, "_busy_drop"}, busy, 0);
        check({tag, "_clip_hold"}, clip, exp_c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] s;
        logic [127:0] g;
        int           tw;

        reset      = 1'b0;
        start      = 1'b0;
        samples_in = '0;
        gains_in   = '0;
        voice_en   = '0;
        mul_ready  = 1'b1;
        #3 reset = 1'b1;
        #1;
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_trigger", mul_trigger, 0);
        check("rst_mix_out", mix_out, 0);
        check("rst_valid", mix_valid, 0);
        check("rst_clip", clip, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge ctl_clk);
        reset = 1'b0;

        // single voice
        lat = 2;
        s = rnd128(); s[15:0] = 16'h4000;
        g = rnd128(); g[15:0] = 16'h8000;
        do_mix("single", 8'h01, s, g, 0, 1'b0, 0);

        // negative extreme magnitude
        s = rnd128(); s[15:0] = 16'h8000;
        g = rnd128(); g[15:0] = 16'hFFFF;
        do_mix("neg_ext", 8'h01, s, g, 0, 1'b0, 0);
        check("neg_ext_mul_a", last_a, 32'h0000_8000);
        check("neg_ext_mul_b", last_b, 32'h0000_FFFF);

        // saturation both directions
        lat = 1;
        do_mix("sat_pos", 8'hFF, {8{16'h7FFF}}, {8{16'hFFFF}}, 0, 1'b0, 0);
        check("sat_pos_value", mix_out, 16'h7FFF);
        do_mix("sat_neg", 8'hFF, {8{16'h8000}}, {8{16'hFFFF}}, 0, 1'b0, 0);
        check("sat_neg_value", mix_out, 16'h8000);

        // all voices disabled
        do_mix("mask0", 8'h00, rnd128(), rnd128(), 0, 1'b0, 9);
        check("mask0_value", mix_out, 0);

        // handshake stress: ready held low, done during trigger, start while busy
        lat     = 3;
        spur_en = 1'b1;
        do_mix("stress", 8'h25, rnd128(), rnd128(), 5, 1'b1, 0);
        spur_en = 1'b0;

        // saturating mix leaves clip set, then reset while WAIT is pending
        do_mix("pre_rst", 8'hFF, {8{16'h7FFF}}, {8{16'hFFFF}}, 0, 1'b0, 0);
        lat = 40;
        @(negedge ctl_clk);
        samples_in = {8{16'h8123}};
        gains_in   = {8{16'hF000}};
        voice_en   = 8'h01;
        start      = 1'b1;
        @(negedge ctl_clk);
        start = 1'b0;
        for (tw = 0; tw < 20 && mul_trigger !== 1'b1; tw++) @(negedge ctl_clk);
        check("rst_wait_reached", mul_trigger, 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_trigger", mul_trigger, 0);
        check("midrst_mul_a", mul_a, 0);
        check("midrst_mul_b", mul_b, 0);
        check("midrst_mix_out", mix_out, 0);
        check("midrst_clip", clip, 0);
        check("midrst_valid", mix_valid, 0);
        check("midrst_busy", busy, 0);
        @(negedge ctl_clk);
        reset      = 1'b0;
        stray_done = 1'b1;
        repeat (2) @(negedge ctl_clk);
        stray_done = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_valid", mix_valid, 0);
        check("stray_mix_out", mix_out, 0);
        lat = 2;
        do_mix("post_rst", 8'h81, rnd128(), rnd128(), 0, 1'b0, 0);

        // randomized mixes
        for (int i = 0; i < 16; i++) begin
            logic [7:0] en;
            s = rnd128();
            g = rnd128();
            for (int v = 0; v < 8; v++) begin
                case ($urandom_range(0, 5))
                    0: s[v*16 +: 16] = 16'h8000;
                    1: s[v*16 +: 16] = 16'h7FFF;
                    2: g[v*16 +: 16] = 16'hFFFF;
                    default: ;
                endcase
            end
            en  = 8'($urandom);
            lat = $urandom_range(1, 4);
            do_mix($sformatf("rnd%0d", i), en, s, g, $urandom_range(0, 6),
                   1'($urandom_range(0, 1)), (en == 8'h00) ? 9 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/voice_mix_sequencer.md
Name: voice_mix_sequencer

Overview:
- Sits directly around the shared `multiplier` block in the synth datapath.
- Feeds it operands over the trigger/ready/done handshake and consumes its product `y`.
- Per mix request, it scales each enabled voice sample by its gain through the multiplier, one voice at a time, and accumulates the results.
- It then emits one saturated signed mix sample to the output stage.

Parameters:
- `C_WIDTH`, 32: multiplier operand/result width; must be ≥ 2*`SAMPLE_WIDTH`.
- `SAMPLE_WIDTH`, 16: voice sample width (signed two's complement) and gain width (unsigned Q0.16).
- `NUM_VOICES`, 8: voices per mix; must be ≥ 2.

Ports:
- `ctl_clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle mix request; ignored while `busy`.
- `samples_in` in `NUM_VOICES`*`SAMPLE_WIDTH`: voice v at bits [v*SW +: SW], signed.
- `gains_in` in `NUM_VOICES`*`SAMPLE_WIDTH`: voice v gain, unsigned Q0.16.
- `voice_en` in `NUM_VOICES`: per-voice enable mask.
- `mul_a` out `C_WIDTH`: multiplier operand a.
- `mul_b` out `C_WIDTH`: multiplier operand b.
- `mul_trigger` out 1: one-cycle multiply request.
- `mul_ready` in 1: multiplier can accept a trigger.
- `mul_done` in 1: multiplier result valid on `mul_y`.
- `mul_y` in `C_WIDTH`: multiplier product (multiplier built with `FIXED_POINT`=0).
- `mix_out` out `SAMPLE_WIDTH`: signed mixed sample.
- `mix_valid` out 1: one-cycle pulse, `mix_out` updated.
- `clip` out 1: last mix saturated; held until next `mix_valid`.
- `busy` out 1: mix in progress.

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; accumulator, index and latched inputs cleared.
- `mul_trigger` drops combinationally-free, i.e. from its register, the same instant reset asserts.
- IDLE:
  - `start`=1 latches `samples_in`, `gains_in` and `voice_en`, clears acc, sets idx=0 and `busy`=1, then goes to SCAN.
  - Inputs may change freely after the latch cycle.
- SCAN (one voice checked per cycle):
  - idx disabled: if idx=NUM_VOICES-1 go to OUTPUT, else idx++.
  - idx enabled: go to ISSUE.
- ISSUE:
  - Drive `mul_a` = zero-extended |sample[idx]| (|-32768| = 32768 fits unsigned) and `mul_b` = zero-extended gain[idx].
  - When `mul_ready`=1, assert `mul_trigger` for exactly one cycle and go to WAIT; otherwise stay with `mul_trigger`=0.
- WAIT:
  - `mul_a`/`mul_b` held stable.
  - `mul_done` is ignored in the cycle `mul_trigger` is high; the first later cycle with `mul_done`=1 captures p = `mul_y`[2*SW-1:SW].
  - This truncates the magnitude, i.e. rounds toward zero symmetrically.
  - acc += (sample negative ? -p : p).
  - Then: if idx=NUM_VOICES-1 go to OUTPUT, else idx++ and go to SCAN.
  - No timeout: WAIT holds indefinitely.
- OUTPUT (1 cycle):
  - `mix_out` = acc clamped to [-2^(SW-1), 2^(SW-1)-1].
  - `clip` = 1 iff clamping occurred.
  - `mix_valid`=1 for this single cycle; `busy`=0 from the next cycle; go to IDLE.
- Widths: acc is signed, SW + clog2(NUM_VOICES) + 1 bits; it can never overflow internally.
- All-disabled mask: no `mul_trigger` is issued; `mix_out`=0, `clip`=0, `mix_valid` pulses NUM_VOICES+1 cycles after `start`.
- `start` coinciding with the OUTPUT cycle is ignored; a new `start` is accepted only in IDLE.
- Reset mid-WAIT abandons the operation; a stray later `mul_done` in IDLE is ignored.

Decomposition:
- Shared header: FSM state encodings (IDLE, SCAN, ISSUE, WAIT, OUTPUT), the SAMPLE_WIDTH/C_WIDTH defaults, and the Q0.16 gain-fraction constant (16), all reused by the envelope and mixer stages.
- One sub-module, `mix_saturate`: combinational signed clamp from acc width to SW with a clip flag.

Test Plan:
1. Single voice: en=8'h01, sample 16'h4000, gain 16'h8000, real multiplier (MUL_TYPE 0..3) → `mix_out`=16'h2000, `clip`=0, exactly one `mul_trigger`.
2. Negative extreme: sample 16'h8000, gain 16'hFFFF, one voice → `mul_a`=32'h8000, `mix_out`=16'h8001 (-32767), `clip`=0.
3. Saturation: all 8 voices 16'h7FFF at gain 16'hFFFF → `mix_out`=16'h7FFF, `clip`=1. Same test with 16'h8000 samples → `mix_out`=16'h8000, `clip`=1.
4. Mask 8'h00 → no `mul_trigger`, `mix_valid` 9 cycles after `start`, `mix_out`=0.
5. Handshake stress with a bench multiplier model:
   - `mul_ready` held low 5 cycles → no trigger until it rises.
   - `mul_done` high in the trigger cycle is ignored.
   - `start` pulsed while `busy` is ignored.
   - Mix of 3 voices (en=8'h25) sums correctly.
6. Reset asserted in WAIT → all outputs 0 immediately, `busy`=0; a following `start` yields the correct mix.
